// File: rtl/subleq_pkg.sv
// Shared definitions for the SUBLEQ sequencer: state encoding, instruction
// field positions and the default halt target.
package subleq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_RD_A   = 3'd3,
        ST_RD_B   = 3'd4,
        ST_WRITE  = 3'd5,
        ST_HALT   = 3'd6
    } state_e;

    localparam int A_MSB = 23;
    localparam int A_LSB = 16;
    localparam int B_MSB = 15;
    localparam int B_LSB = 8;
    localparam int C_MSB = 7;
    localparam int C_LSB = 0;

    localparam logic [7:0] DEFAULT_HALT_ADDR = 8'hFF;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
    } instr_t;

endpackage

// File: rtl/subleq_if.sv
// Program ROM and data RAM bus seen by the sequencer; the controller is the
// only master of both memories.
interface subleq_if;

    logic [7:0]  rom_addr;
    logic [23:0] rom_data;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_rdata;
    logic [7:0]  mem_wdata;
    logic        mem_we;

    modport master (
        output rom_addr,
        input  rom_data,
        output mem_addr,
        input  mem_rdata,
        output mem_wdata,
        output mem_we
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        input  mem_addr,
        output mem_rdata,
        input  mem_wdata,
        input  mem_we
    );

endinterface

// File: rtl/subleq_alu.sv
// Combinational SUBLEQ arithmetic: wrapped difference mem[B]-mem[A] and the
// less-or-equal-to-zero branch condition taken from that wrapped result.
module subleq_alu (
    input  logic [7:0] op_a,
    input  logic [7:0] op_b,
    output logic [7:0] result,
    output logic       leq
);

    assign result = op_b - op_a;
    assign leq    = result[7] | (result == 8'h00);

endmodule

// File: rtl/subleq_ctrl.sv
// SUBLEQ instruction sequencer: fetch, read A and B, write back B-A, then
// branch or fall through; halts on a taken branch to HALT_ADDR.
module subleq_ctrl
    import subleq_pkg::*;
#(
    parameter logic [7:0] HALT_ADDR = DEFAULT_HALT_ADDR
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            run,
    input  logic            step,
    subleq_if.master        bus,
    output logic [7:0]      pc,
    output logic            busy,
    output logic            retire,
    output logic            halted
);

    state_e     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    instr_t     ir_q, ir_d;
    logic [7:0] op_a_q, op_a_d;
    logic [7:0] op_b_q, op_b_d;

    logic [7:0] result;
    logic       leq;
    logic       write_en;

    subleq_alu u_alu (
        .op_a   (op_a_q),
        .op_b   (op_b_q),
        .result (result),
        .leq    (leq)
    );

    // NOTE: sequential state uses non-blocking assignments only; every
    // register, including the operand/instruction latches, is reset so the
    // buses come out of reset at known values.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            pc_q    <= 8'h00;
            ir_q    <= '0;
            op_a_q  <= 8'h00;
            op_b_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
        end
    end

    // NOTE: every signal written below gets a default first so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        bus.rom_addr = pc_q;
        bus.mem_addr = 8'h00;
        bus.mem_wdata = 8'h00;
        write_en     = 1'b0;
        retire       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (run || step) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                ir_d         = instr_t'(bus.rom_data);
                bus.mem_addr = bus.rom_data[A_MSB:A_LSB];
                state_d      = ST_RD_A;
            end
            ST_RD_A: begin
                op_a_d       = bus.mem_rdata;
                bus.mem_addr = ir_q.b;
                state_d      = ST_RD_B;
            end
            ST_RD_B: begin
                op_b_d       = bus.mem_rdata;
                bus.mem_addr = ir_q.b;
                state_d      = ST_WRITE;
            end
            ST_WRITE: begin
                bus.mem_addr  = ir_q.b;
                bus.mem_wdata = result;
                write_en      = 1'b1;
                retire        = 1'b1;
                pc_d          = leq ? ir_q.c : pc_q + 8'd1;
                if (leq && (ir_q.c == HALT_ADDR)) state_d = ST_HALT;
                else if (run)                      state_d = ST_FETCH;
                else                               state_d = ST_IDLE;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A reset landing on the WRITE edge abandons the instruction, so
        // the RAM must not see the write either.
        bus.mem_we = write_en & RST_N;
    end

    assign pc     = pc_q;
    assign busy   = (state_q != ST_IDLE) && (state_q != ST_HALT);
    assign halted = (state_q == ST_HALT);

endmodule

// File: tb/tb_subleq_ctrl.sv
// Directed self-checking bench for subleq_ctrl with behavioural ROM and RAM
// attached to the bus interface.
module tb_subleq_ctrl;

    logic       CLK   = 1'b0;
    logic       RST_N = 1'b0;
    logic       run   = 1'b0;
    logic       step  = 1'b0;
    logic [7:0] pc;
    logic       busy;
    logic       retire;
    logic       halted;

    logic [23:0] rom [256];
    logic [7:0]  mem [256];

    int total = 0;
    int bad   = 0;

    subleq_if bus ();

    subleq_ctrl #(.HALT_ADDR(8'hFF)) dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .run    (run),
        .step   (step),
        .bus    (bus.master),
        .pc     (pc),
        .busy   (busy),
        .retire (retire),
        .halted (halted)
    );

    always #5 CLK = ~CLK;

    // Synchronous ROM and RAM: read data one cycle after the address.
    always @(posedge CLK) begin
        bus.rom_data  <= rom[bus.rom_addr];
        bus.mem_rdata <= mem[bus.mem_addr];
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset;
        RST_N = 1'b0;
        run   = 1'b0;
        step  = 1'b0;
        tick();
        tick();
        RST_N = 1'b1;
    endtask

    task automatic pulse_step;
        step = 1'b1;
        tick();
        step = 1'b0;
    endtask

    task automatic wait_retire(input string tag, output int n);
        n = 0;
        while (!retire && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_retire_seen"}, retire, 1);
    endtask

    task automatic clear_mems;
        for (int i = 0; i < 256; i++) begin
            rom[i] = 24'h0;
            mem[i] = 8'h0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int we_cnt;
        int busy_cnt;

        clear_mems();
        tick();

        // Reset values
        do_reset();
        check("rst_pc",     pc, 8'h00);
        check("rst_rom",    bus.rom_addr, 8'h00);
        check("rst_maddr",  bus.mem_addr, 8'h00);
        check("rst_wdata",  bus.mem_wdata, 8'h00);
        check("rst_we",     bus.mem_we, 0);
        check("rst_busy",   busy, 0);
        check("rst_retire", retire, 0);
        check("rst_halted", halted, 0);

        // Fall-through via step
        rom[8'h00] = {8'h10, 8'h11, 8'h05};
        mem[8'h10] = 8'd3;
        mem[8'h11] = 8'd9;
        pulse_step();
        check("ft_busy", busy, 1);
        wait_retire("ft", n);
        check("ft_latency", n, 4);
        check("ft_we",    bus.mem_we, 1);
        check("ft_maddr", bus.mem_addr, 8'h11);
        check("ft_wdata", bus.mem_wdata, 8'h06);
        tick();
        check("ft_mem",    mem[8'h11], 8'h06);
        check("ft_pc",     pc, 8'h01);
        check("ft_retire_once", retire, 0);
        check("ft_idle",   busy, 0);
        tick();
        tick();
        check("ft_stay_idle", busy, 0);

        // Taken branch on zero (A==B)
        do_reset();
        clear_mems();
        rom[8'h00] = {8'h20, 8'h20, 8'h40};
        mem[8'h20] = 8'd7;
        pulse_step();
        wait_retire("tz", n);
        tick();
        check("tz_mem", mem[8'h20], 8'h00);
        check("tz_pc",  pc, 8'h40);

        // Wrap and negative; a step while busy must be ignored
        do_reset();
        clear_mems();
        rom[8'h00] = {8'h30, 8'h31, 8'h50};
        rom[8'h01] = {8'h32, 8'h33, 8'h60};
        mem[8'h30] = 8'h01;
        mem[8'h31] = 8'h80;
        mem[8'h32] = 8'h01;
        mem[8'h33] = 8'h00;
        pulse_step();
        pulse_step();
        wait_retire("wn1", n);
        check("wn1_wdata", bus.mem_wdata, 8'h7F);
        tick();
        check("wn1_pc",  pc, 8'h01);
        check("wn1_mem", mem[8'h31], 8'h7F);
        tick();
        tick();
        check("wn1_step_ignored", busy, 0);
        pulse_step();
        wait_retire("wn2", n);
        check("wn2_wdata", bus.mem_wdata, 8'hFF);
        tick();
        check("wn2_pc",  pc, 8'h60);
        check("wn2_mem", mem[8'h33], 8'hFF);

        // Halt under run (run and step both high at start)
        do_reset();
        clear_mems();
        rom[8'h00] = {8'h00, 8'h00, 8'hFF};
        mem[8'h00] = 8'd5;
        run  = 1'b1;
        step = 1'b1;
        tick();
        step = 1'b0;
        wait_retire("ht", n);
        tick();
        check("ht_halted", halted, 1);
        check("ht_busy",   busy, 0);
        check("ht_pc",     pc, 8'hFF);
        check("ht_mem",    mem[8'h00], 8'h00);
        we_cnt   = 0;
        busy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step = i[0];
            if (bus.mem_we) we_cnt++;
            if (busy) busy_cnt++;
            tick();
        end
        step = 1'b0;
        check("ht_no_we",   we_cnt, 0);
        check("ht_no_busy", busy_cnt, 0);
        check("ht_sticky",  halted, 1);
        do_reset();
        check("ht_cleared", halted, 0);

        // PC wrap and run drop during RD_A
        clear_mems();
        rom[8'h00] = {8'h40, 8'h40, 8'hFE};
        rom[8'hFE] = {8'h41, 8'h42, 8'h10};
        rom[8'hFF] = {8'h43, 8'h44, 8'h10};
        mem[8'h40] = 8'd3;
        mem[8'h41] = 8'd1;
        mem[8'h42] = 8'd5;
        mem[8'h43] = 8'd1;
        mem[8'h44] = 8'd9;
        run = 1'b1;
        tick();
        wait_retire("pw0", n);
        tick();
        check("pw_pc_fe", pc, 8'hFE);
        wait_retire("pw1", n);
        check("pw1_wdata", bus.mem_wdata, 8'h04);
        tick();
        check("pw_pc_ff", pc, 8'hFF);
        tick();
        tick();
        check("pw_rda_addr", bus.mem_addr, 8'h44);
        run = 1'b0;
        wait_retire("pw2", n);
        check("pw2_wdata", bus.mem_wdata, 8'h08);
        tick();
        check("pw_pc_wrap", pc, 8'h00);
        check("pw_idle",    busy, 0);
        check("pw_mem",     mem[8'h44], 8'h08);
        tick();
        tick();
        check("pw_stay_idle", busy, 0);

        // Reset asserted during WRITE
        do_reset();
        clear_mems();
        rom[8'h00] = {8'h50, 8'h51, 8'h00};
        mem[8'h50] = 8'd2;
        mem[8'h51] = 8'd7;
        pulse_step();
        wait_retire("rw", n);
        RST_N = 1'b0;
        tick();
        check("rw_we",   bus.mem_we, 0);
        check("rw_pc",   pc, 8'h00);
        check("rw_busy", busy, 0);
        check("rw_mem",  mem[8'h51], 8'h07);
        RST_N = 1'b1;
        tick();
        check("rw_we_after",  bus.mem_we, 0);
        check("rw_mem_after", mem[8'h51], 8'h07);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
